rename_table: RTL

Parametrised register rename unit: speculative map table, committed map table, circular free-tag list, and per-physical-register ready bits. Renames up to RENAME_WIDTH instructions per cycle with intra-group dependency bypass. Frees old tags on in-order commit and restores the speculative state on flush. Sits between decode and issue, and replaces the single-tag allocator and map stub.

---
 rtl/rename_table.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/rename_table.sv
// rename_table: register rename unit.
//   Speculative and committed arch->phys map tables, a circular free-tag list
//   and per-physical-register ready bits. Renames RENAME_WIDTH instructions per
//   cycle with intra-group dependency bypass. Frees old tags on in-order commit
//   and restores the speculative state on flush.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   rn_valid/rn_ready      rename group handshake (all-or-nothing)
//   rn_dst_wr, rn_src1/2,  per-slot destination-write flag and arch registers
//   rn_dst
//   out_valid, out_psrc1/2 registered rename result: physical sources,
//   out_pdst, out_pold     new destination tag, previous destination mapping
//   out_rdy1/2             source operand ready flags
//   wb_valid, wb_tag       writeback ports, mark tags ready
//   cm_valid, cm_dst_wr,   in-order commit slots
//   cm_arch, cm_pdst,
//   cm_pold
//   flush                  discard all uncommitted renames
//   out_of_tags            equals !rn_ready
module rename_table #(
    parameter int unsigned NUM_ARCH     = 16,
    parameter int unsigned NUM_PHYS     = 64,
    parameter int unsigned RENAME_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned WB_WIDTH     = 2,
    localparam int unsigned AW = $clog2(NUM_ARCH),
    localparam int unsigned PW = $clog2(NUM_PHYS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rn_valid,
    output logic                         rn_ready,
    input  logic [RENAME_WIDTH-1:0]      rn_dst_wr,
    input  logic [RENAME_WIDTH*AW-1:0]   rn_src1,
    input  logic [RENAME_WIDTH*AW-1:0]   rn_src2,
    input  logic [RENAME_WIDTH*AW-1:0]   rn_dst,
    output logic                         out_valid,
    output logic [RENAME_WIDTH*PW-1:0]   out_psrc1,
    output logic [RENAME_WIDTH*PW-1:0]   out_psrc2,
    output logic [RENAME_WIDTH*PW-1:0]   out_pdst,
    output logic [RENAME_WIDTH*PW-1:0]   out_pold,
    output logic [RENAME_WIDTH-1:0]      out_rdy1,
    output logic [RENAME_WIDTH-1:0]      out_rdy2,
    input  logic [WB_WIDTH-1:0]          wb_valid,
    input  logic [WB_WIDTH*PW-1:0]       wb_tag,
    input  logic [COMMIT_WIDTH-1:0]      cm_valid,
    input  logic [COMMIT_WIDTH-1:0]      cm_dst_wr,
    input  logic [COMMIT_WIDTH*AW-1:0]   cm_arch,
    input  logic [COMMIT_WIDTH*PW-1:0]   cm_pdst,
    input  logic [COMMIT_WIDTH*PW-1:0]   cm_pold,
    input  logic                         flush,
    output logic                         out_of_tags
);

    localparam logic [PW:0] PtrOne    = (PW+1)'(1);
    localparam logic [PW:0] GroupTags = (PW+1)'(RENAME_WIDTH);

    logic [PW-1:0]             spec_map_q  [NUM_ARCH];
    logic [PW-1:0]             spec_map_d  [NUM_ARCH];
    logic [PW-1:0]             cm_map_q    [NUM_ARCH];
    logic [PW-1:0]             cm_map_d    [NUM_ARCH];
    logic [PW-1:0]             free_list_q [NUM_PHYS];
    logic [PW-1:0]             free_list_d [NUM_PHYS];
    logic [NUM_PHYS-1:0]       ready_q, ready_d;
    logic [PW:0]               head_q, head_d, tail_q, tail_d, chead_q, chead_d;

    logic                      out_valid_q;
    logic [RENAME_WIDTH*PW-1:0] psrc1_q, psrc1_d, psrc2_q, psrc2_d;
    logic [RENAME_WIDTH*PW-1:0] pdst_q, pdst_d, pold_q, pold_d;
    logic [RENAME_WIDTH-1:0]   rdy1_q, rdy1_d, rdy2_q, rdy2_d;

    logic [PW:0]               free_count;
    logic [PW:0]               alloc_end;
    logic [NUM_PHYS-1:0]       wb_mask;
    logic                      accept;

    // Pointers carry one extra wrap bit, so tail - head is the free count.
    assign free_count  = tail_q - head_q;
    assign rn_ready    = (free_count >= GroupTags) && !flush;
    assign out_of_tags = !rn_ready;
    assign accept      = rn_valid && rn_ready;

    always_comb begin
        wb_mask = '0;
        for (int w = 0; w < WB_WIDTH; w++) begin
            if (wb_valid[w]) wb_mask[wb_tag[w*PW +: PW]] = 1'b1;
        end
    end

    // Group rename: map lookup, then override by the nearest earlier writer.
    always_comb begin
        logic [PW:0]   alloc;
        logic [AW-1:0] s1, s2, d;
        alloc  = head_q;
        psrc1_d = '0;
        psrc2_d = '0;
        pdst_d  = '0;
        pold_d  = '0;
        rdy1_d  = '0;
        rdy2_d  = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            s1 = rn_src1[i*AW +: AW];
            s2 = rn_src2[i*AW +: AW];
            d  = rn_dst[i*AW +: AW];
            psrc1_d[i*PW +: PW] = spec_map_q[s1];
            psrc2_d[i*PW +: PW] = spec_map_q[s2];
            pold_d[i*PW +: PW]  = spec_map_q[d];
            // A tag being written back this cycle is already ready.
            rdy1_d[i] = ready_q[spec_map_q[s1]] | wb_mask[spec_map_q[s1]];
            rdy2_d[i] = ready_q[spec_map_q[s2]] | wb_mask[spec_map_q[s2]];
            for (int j = 0; j < i; j++) begin
                if (rn_dst_wr[j] && rn_dst[j*AW +: AW] == s1) begin
                    psrc1_d[i*PW +: PW] = pdst_d[j*PW +: PW];
                    rdy1_d[i]           = 1'b0;
                end
                if (rn_dst_wr[j] && rn_dst[j*AW +: AW] == s2) begin
                    psrc2_d[i*PW +: PW] = pdst_d[j*PW +: PW];
                    rdy2_d[i]           = 1'b0;
                end
                if (rn_dst_wr[j] && rn_dst[j*AW +: AW] == d) begin
                    pold_d[i*PW +: PW] = pdst_d[j*PW +: PW];
                end
            end
            if (rn_dst_wr[i]) begin
                pdst_d[i*PW +: PW] = free_list_q[alloc[PW-1:0]];
                alloc              = alloc + PtrOne;
            end else begin
                pold_d[i*PW +: PW] = '0;
            end
        end
        alloc_end = alloc;
    end

    // Table, free-list and ready-bit updates: rename, writeback, commit, flush.
    always_comb begin
        spec_map_d  = spec_map_q;
        cm_map_d    = cm_map_q;
        free_list_d = free_list_q;
        ready_d     = ready_q;
        head_d      = head_q;
        tail_d      = tail_q;
        chead_d     = chead_q;
        if (accept) begin
            head_d = alloc_end;
            // Later slots overwrite earlier ones, so the highest slot wins.
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (rn_dst_wr[i]) begin
                    spec_map_d[rn_dst[i*AW +: AW]] = pdst_d[i*PW +: PW];
                    ready_d[pdst_d[i*PW +: PW]]    = 1'b0;
                end
            end
        end
        ready_d = ready_d | wb_mask;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (cm_valid[c] && cm_dst_wr[c]) begin
                free_list_d[tail_d[PW-1:0]]     = cm_pold[c*PW +: PW];
                tail_d                          = tail_d + PtrOne;
                cm_map_d[cm_arch[c*AW +: AW]]   = cm_pdst[c*PW +: PW];
                chead_d                         = chead_d + PtrOne;
            end
        end
        if (flush) begin
            // Tags between chead and head were never committed: hand them back.
            head_d     = chead_d;
            spec_map_d = cm_map_d;
            ready_d    = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ARCH; i++) begin
                spec_map_q[i] <= PW'(i);
                cm_map_q[i]   <= PW'(i);
            end
            for (int unsigned k = 0; k < NUM_PHYS; k++) begin
                free_list_q[k] <= (k < NUM_PHYS - NUM_ARCH) ? PW'(NUM_ARCH + k) : '0;
            end
            ready_q     <= '1;
            head_q      <= '0;
            chead_q     <= '0;
            tail_q      <= (PW+1)'(NUM_PHYS - NUM_ARCH);
            out_valid_q <= 1'b0;
            psrc1_q     <= '0;
            psrc2_q     <= '0;
            pdst_q      <= '0;
            pold_q      <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
        end else begin
            spec_map_q  <= spec_map_d;
            cm_map_q    <= cm_map_d;
            free_list_q <= free_list_d;
            ready_q     <= ready_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            chead_q     <= chead_d;
            out_valid_q <= accept;
            psrc1_q     <= psrc1_d;
            psrc2_q     <= psrc2_d;
            pdst_q      <= pdst_d;
            pold_q      <= pold_d;
            rdy1_q      <= rdy1_d;
            rdy2_q      <= rdy2_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_psrc1 = psrc1_q;
    assign out_psrc2 = psrc2_q;
    assign out_pdst  = pdst_q;
    assign out_pold  = pold_q;
    assign out_rdy1  = rdy1_q;
    assign out_rdy2  = rdy2_q;

endmodule
